// File: rtl/bcd_serial_add_ctrl.sv
// Digit-serial packed-BCD adder: one shared single-digit cell, LSD first, start/busy/done handshake.
// Optional invalid-digit checker enabled by defining BCD_DIGIT_CHECK_EN.
module bcd_serial_add_ctrl #(
    parameter int unsigned DIGITS = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [4*DIGITS-1:0]   a,
    input  logic [4*DIGITS-1:0]   b,
    input  logic                  cin,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   result,
    output logic                  cout,
    output logic                  err
);

    localparam int unsigned IdxW = $clog2(DIGITS);

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StFin
    } state_e;

    state_e                state_q, state_d;
    logic [4*DIGITS-1:0]   a_sh_q, b_sh_q;
    logic [4*DIGITS-1:0]   result_q;
    logic [IdxW-1:0]       idx_q;
    logic                  carry_q;
    logic                  cout_q;
    logic                  done_q;
    logic                  accept;
    logic                  last_digit;

    logic [3:0]            cell_x, cell_y, cell_sum;
    logic [4:0]            cell_raw;
    logic                  cell_cout;

    assign last_digit = (idx_q == IdxW'(DIGITS - 1));

    // Single-digit decimal adder cell
    assign cell_x    = a_sh_q[{idx_q, 2'b00} +: 4];
    assign cell_y    = b_sh_q[{idx_q, 2'b00} +: 4];
    assign cell_raw  = {1'b0, cell_x} + {1'b0, cell_y} + {4'b0000, carry_q};
    assign cell_cout = (cell_raw > 5'd9);
    assign cell_sum  = cell_cout ? (cell_raw[3:0] + 4'd6) : cell_raw[3:0];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    accept  = 1'b1;
                    state_d = StRun;
                end
            end
            StRun: begin
                if (last_digit) begin
                    state_d = StFin;
                end
            end
            StFin: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            a_sh_q   <= '0;
            b_sh_q   <= '0;
            result_q <= '0;
            idx_q    <= '0;
            carry_q  <= 1'b0;
            cout_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (accept) begin
                a_sh_q  <= a;
                b_sh_q  <= b;
                carry_q <= cin;
                idx_q   <= '0;
            end
            if (state_q == StRun) begin
                result_q[{idx_q, 2'b00} +: 4] <= cell_sum;
                carry_q                       <= cell_cout;
                if (!last_digit) begin
                    idx_q <= idx_q + 1'b1;
                end
            end
            // done is registered so it lands one cycle after FIN, when busy has dropped
            if (state_q == StFin) begin
                cout_q <= carry_q;
                done_q <= 1'b1;
            end
        end
    end

    assign busy   = (state_q != StIdle);
    assign done   = done_q;
    assign result = result_q;
    assign cout   = cout_q;

`ifdef BCD_DIGIT_CHECK_EN
    logic bad_digit;
    logic err_q;

    always_comb begin
        bad_digit = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            if ((a[4*i +: 4] > 4'd9) || (b[4*i +: 4] > 4'd9)) begin
                bad_digit = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            err_q <= 1'b0;
        end else if (accept) begin
            err_q <= bad_digit;
        end
    end

    assign err = err_q;
`else
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_bcd_serial_add_ctrl.sv
// Scoreboard bench for bcd_serial_add_ctrl (DIGITS=4): stimulus pushes expected results,
// a negedge monitor pops and compares on every done pulse.
module tb_bcd_serial_add_ctrl;

    localparam int unsigned DIGITS = 4;
    localparam int unsigned W      = 4 * DIGITS;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic [W-1:0] a, b;
    logic         cin;
    logic         busy, done, cout, err;
    logic [W-1:0] result;

    typedef struct packed {
        logic [W-1:0] res;
        logic         co;
        logic         er;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   n_done   = 0;
    int   n_pushed = 0;

    bcd_serial_add_ctrl #(.DIGITS(DIGITS)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .a      (a),
        .b      (b),
        .cin    (cin),
        .busy   (busy),
        .done   (done),
        .result (result),
        .cout   (cout),
        .err    (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

`ifdef BCD_DIGIT_CHECK_EN
    localparam logic ErrOnBad = 1'b1;
`else
    localparam logic ErrOnBad = 1'b0;
`endif

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: every done pulse must match the oldest outstanding expectation
    always @(negedge clk) begin
        if (rst_n && done) begin
            n_done++;
            if (sb.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_done: got done=1 expected no done");
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("sb_result", 32'(result), 32'(e.res));
                check("sb_cout", 32'(cout), 32'(e.co));
                check("sb_err", 32'(err), 32'(e.er));
            end
        end
    end

    // Drive start for one cycle; returns after the accepting edge (+1)
    task automatic issue(input logic [W-1:0] ia, input logic [W-1:0] ib, input logic ic,
                         input logic push, input exp_t e);
        @(negedge clk);
        start = 1'b1;
        a     = ia;
        b     = ib;
        cin   = ic;
        if (push) begin
            sb.push_back(e);
            n_pushed++;
        end
        @(posedge clk);
        #1;
        start = 1'b0;
        a     = 16'hFFFF;  // shadow registers must hide this
        b     = 16'h9999;
        cin   = 1'b1;
    endtask

    task automatic wait_done(input string name, input int exp_lat);
        int k;
        k = 0;
        for (int i = 1; i <= 20; i++) begin
            if (k == 0) begin
                @(posedge clk);
                #1;
                if (done) k = i;
            end
        end
        if (k == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s_timeout: got no done in 20 cycles expected done", name);
        end else if (exp_lat > 0) begin
            check({name, "_latency"}, 32'(k), 32'(exp_lat));
            check({name, "_busy_at_done"}, 32'(busy), 32'd0);
        end
    endtask

    task automatic run_op(input string name, input logic [W-1:0] ia, input logic [W-1:0] ib,
                          input logic ic, input logic [W-1:0] er, input logic ec,
                          input logic ee);
        exp_t e;
        e.res = er;
        e.co  = ec;
        e.er  = ee;
        issue(ia, ib, ic, 1'b1, e);
        check({name, "_busy"}, 32'(busy), 32'd1);
        wait_done(name, DIGITS + 1);
    endtask

    initial begin
        exp_t dummy;
        dummy = '0;
        rst_n = 1'b0;
        start = 1'b0;
        a     = '0;
        b     = '0;
        cin   = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;

        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_result", 32'(result), 32'd0);
        check("rst_cout", 32'(cout), 32'd0);
        check("rst_err", 32'(err), 32'd0);

        run_op("add_1234_5678", 16'h1234, 16'h5678, 1'b0, 16'h6912, 1'b0, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        check("result_hold", 32'(result), 32'h6912);
        check("idle_busy", 32'(busy), 32'd0);

        run_op("ripple_9999", 16'h9999, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0);
        run_op("cin_only", 16'h0000, 16'h0000, 1'b1, 16'h0001, 1'b0, 1'b0);
        run_op("both_carry", 16'h5000, 16'h5000, 1'b1, 16'h0001, 1'b1, 1'b0);
        run_op("mid_ripple", 16'h0999, 16'h0001, 1'b0, 16'h1000, 1'b0, 1'b0);

        // Start re-pulsed during RUN with new operands: ignored
        begin
            exp_t e;
            e.res = 16'h3333;
            e.co  = 1'b0;
            e.er  = 1'b0;
            issue(16'h1111, 16'h2222, 1'b0, 1'b1, e);
            start = 1'b1;
            a     = 16'h8888;
            b     = 16'h0000;
            @(posedge clk);
            #1;
            start = 1'b0;
            wait_done("ignored_start", 0);
            repeat (4) @(posedge clk);
            #1;
            check("ignored_no_restart", 32'(busy), 32'd0);
        end

        // Reset mid-RUN: aborts with no done
        issue(16'h4444, 16'h4444, 1'b0, 1'b0, dummy);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_result", 32'(result), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        repeat (8) @(posedge clk);
        #1;
        check("abort_still_idle", 32'(busy), 32'd0);

        run_op("after_abort", 16'h2468, 16'h1357, 1'b0, 16'h3825, 1'b0, 1'b0);
        run_op("bad_digit", 16'h12A4, 16'h0001, 1'b0, 16'h1305, 1'b0, ErrOnBad);
        run_op("err_clears", 16'h0001, 16'h0001, 1'b0, 16'h0002, 1'b0, 1'b0);

        repeat (3) @(posedge clk);
        #1;
        check("sb_drained", 32'(sb.size()), 32'd0);
        check("done_count", 32'(n_done), 32'(n_pushed));

        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
        $finish;
    end

endmodule
